// File: rtl/fifo_read_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_read_ctrl
//   Read-side controller of an asynchronous FIFO. It brings the write-domain
//   Gray pointer into rclk through a two-flop synchroniser and keeps the binary
//   and Gray read pointers. It derives a registered empty flag and drives the
//   address of the dual-port memory's combinational read port. Popped words are
//   presented on a registered first-word-fall-through valid/ready stream.
//
// Optional build macro: FIFO_RD_LEVEL_EN adds the rlevel occupancy output.
//
// Ports
//   rclk       in   read-domain clock, all state on posedge
//   rrst       in   asynchronous active-high reset
//   wptr       in   write pointer (Gray, wclk domain, unsynchronised)
//   rdata_mem  in   memory read data, combinational function of raddr
//   raddr      out  memory read address
//   rptr       out  registered Gray read pointer, to the write side
//   rclk_en    out  memory read strobe, high in cycles where a word is popped
//   rempty     out  registered FIFO-empty flag
//   rd_data    out  stream data
//   rd_valid   out  stream valid
//   rd_ready   in   stream ready from the consumer
//   rlevel     out  occupancy (FIFO_RD_LEVEL_EN only)
// -----------------------------------------------------------------------------
module fifo_read_ctrl #(
   parameter int DATA_SIZE = 8,
   parameter int ADDR_SIZE = 4
) (
   input  logic                 rclk,
   input  logic                 rrst,
   input  logic [ADDR_SIZE:0]   wptr,
   input  logic [DATA_SIZE-1:0] rdata_mem,
   output logic [ADDR_SIZE-1:0] raddr,
   output logic [ADDR_SIZE:0]   rptr,
   output logic                 rclk_en,
   output logic                 rempty,
   output logic [DATA_SIZE-1:0] rd_data,
   output logic                 rd_valid,
   input  logic                 rd_ready
`ifdef FIFO_RD_LEVEL_EN
   ,
   output logic [ADDR_SIZE:0]   rlevel
`endif
);

   logic [ADDR_SIZE:0]   r_q1_wptr;
   logic [ADDR_SIZE:0]   r_q2_wptr;
   logic [ADDR_SIZE:0]   r_bin;
   logic [ADDR_SIZE:0]   r_ptr;
   logic                 r_empty;
   logic                 r_valid;
   logic [DATA_SIZE-1:0] r_data;

   logic                 w_pop;
   logic [ADDR_SIZE:0]   w_bin_next;
   logic [ADDR_SIZE:0]   w_gray_next;

   // A word leaves memory whenever one exists and the output register is
   // either empty or being drained in this same cycle.
   always_comb begin
      w_pop       = !r_empty && (!r_valid || rd_ready);
      w_bin_next  = r_bin + {{ADDR_SIZE{1'b0}}, w_pop};
      w_gray_next = (w_bin_next >> 1) ^ w_bin_next;
   end

   // Two-flop synchroniser; nothing else may look at wptr.
   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) begin
         r_q1_wptr <= '0;
         r_q2_wptr <= '0;
      end else begin
         r_q1_wptr <= wptr;
         r_q2_wptr <= r_q1_wptr;
      end
   end

   // Pointers and empty flag. Comparing the next Gray pointer against the
   // synchronised write pointer keeps rempty registered; it can only lag the
   // true state on the "data available" side, never report data that is absent.
   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) begin
         r_bin   <= '0;
         r_ptr   <= '0;
         r_empty <= 1'b1;
      end else begin
         r_bin   <= w_bin_next;
         r_ptr   <= w_gray_next;
         r_empty <= (w_gray_next == r_q2_wptr);
      end
   end

   // Output register. A pop takes priority, so a transfer and a refill in the
   // same edge sustain one word per cycle.
   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (w_pop) begin
         r_valid <= 1'b1;
         r_data  <= rdata_mem;
      end else if (r_valid && rd_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign raddr    = r_bin[ADDR_SIZE-1:0];
   assign rptr     = r_ptr;
   assign rclk_en  = w_pop;
   assign rempty   = r_empty;
   assign rd_data  = r_data;
   assign rd_valid = r_valid;

`ifdef FIFO_RD_LEVEL_EN
   // Gray-to-binary of the synchronised write pointer: each binary bit is the
   // XOR of all Gray bits at or above it.
   logic [ADDR_SIZE:0] w_wbin;
   genvar gi;
   generate
      for (gi = 0; gi <= ADDR_SIZE; gi++) begin : g_gray2bin
         assign w_wbin[gi] = ^r_q2_wptr[ADDR_SIZE:gi];
      end
   endgenerate

   // Modulo subtraction; the word parked in the output register is not counted.
   assign rlevel = w_wbin - r_bin;
`endif

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_read_ctrl
//   Self-checking bench for fifo_read_ctrl. The write side is modelled as a word
//   counter plus a 16-entry memory; wptr is the Gray code of that counter.
//   Expected behaviour comes from a vector table for single-word/backpressure
//   timing, hand sequences for burst, reset and level, and a randomized run
//   checked against a queue-based FIFO model.
// -----------------------------------------------------------------------------
module tb_fifo_read_ctrl;

   localparam int DW = 8;
   localparam int AW = 4;

   logic          rclk = 1'b0;
   logic          rrst = 1'b1;
   logic          rd_ready = 1'b0;
   logic [DW-1:0] mem [16];
   int            wcnt = 0;
   logic [AW:0]   wbin5;
   logic [AW:0]   wptr;
   logic [DW-1:0] rdata_mem;
   logic [AW-1:0] raddr;
   logic [AW:0]   rptr;
   logic          rclk_en;
   logic          rempty;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
`ifdef FIFO_RD_LEVEL_EN
   logic [AW:0]   rlevel;
`endif

   assign wbin5     = wcnt[AW:0];
   assign wptr      = wbin5 ^ (wbin5 >> 1);
   assign rdata_mem = mem[raddr];

   always #5 rclk = ~rclk;

   fifo_read_ctrl #(.DATA_SIZE(DW), .ADDR_SIZE(AW)) dut (
      .rclk      (rclk),
      .rrst      (rrst),
      .wptr      (wptr),
      .rdata_mem (rdata_mem),
      .raddr     (raddr),
      .rptr      (rptr),
      .rclk_en   (rclk_en),
      .rempty    (rempty),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .rd_ready  (rd_ready)
`ifdef FIFO_RD_LEVEL_EN
      ,
      .rlevel    (rlevel)
`endif
   );

   int            n_checks = 0;
   int            n_fail = 0;
   int            n_done = 0;
   logic [DW-1:0] exp_q [$];

   typedef struct {
      logic          ready;
      int            wtot;
      logic          e_empty;
      logic          e_valid;
      logic [DW-1:0] e_data;
      logic [AW:0]   e_rptr;
      logic          e_en;
   } vec_t;

   vec_t tbl [16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [AW:0] gray5(input int b);
      logic [AW:0] x;
      x = b[AW:0];
      return x ^ (x >> 1);
   endfunction

   task automatic tick();
      @(posedge rclk);
      #1;
   endtask

   task automatic write_word(input logic [DW-1:0] d);
      mem[wcnt[3:0]] = d;
      exp_q.push_back(d);
      wcnt++;
   endtask

   task automatic do_reset();
      rrst     = 1'b1;
      rd_ready = 1'b0;
      wcnt     = 0;
      n_done   = 0;
      exp_q.delete();
      tick();
      tick();
      rrst = 1'b0;
   endtask

   initial begin
      logic [DW-1:0] d;
      logic [DW-1:0] prev_data;
      logic [DW-1:0] e;
      logic          prev_hold;
      int            popped;
      int            first_c;
      int            last_c;
      int            cnt;
      int            cyc;
      int            batch;
      bit            seen;

      // wtot = cumulative words written; word 0 = A5, words 1..3 = B0..B2
      tbl[0]  = '{1'b1, 1, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0};
      tbl[1]  = '{1'b1, 1, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0};
      tbl[2]  = '{1'b1, 1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b1};
      tbl[3]  = '{1'b1, 1, 1'b1, 1'b1, 8'hA5, 5'd1, 1'b0};
      tbl[4]  = '{1'b1, 1, 1'b1, 1'b0, 8'hA5, 5'd1, 1'b0};
      tbl[5]  = '{1'b0, 4, 1'b1, 1'b0, 8'hA5, 5'd1, 1'b0};
      tbl[6]  = '{1'b0, 4, 1'b1, 1'b0, 8'hA5, 5'd1, 1'b0};
      tbl[7]  = '{1'b0, 4, 1'b0, 1'b0, 8'hA5, 5'd1, 1'b1};
      tbl[8]  = '{1'b0, 4, 1'b0, 1'b1, 8'hB0, 5'd3, 1'b0};
      tbl[9]  = '{1'b0, 4, 1'b0, 1'b1, 8'hB0, 5'd3, 1'b0};
      tbl[10] = '{1'b0, 4, 1'b0, 1'b1, 8'hB0, 5'd3, 1'b0};
      tbl[11] = '{1'b0, 4, 1'b0, 1'b1, 8'hB0, 5'd3, 1'b0};
      tbl[12] = '{1'b0, 4, 1'b0, 1'b1, 8'hB0, 5'd3, 1'b0};
      tbl[13] = '{1'b1, 4, 1'b0, 1'b1, 8'hB1, 5'd2, 1'b1};
      tbl[14] = '{1'b1, 4, 1'b1, 1'b1, 8'hB2, 5'd6, 1'b0};
      tbl[15] = '{1'b1, 4, 1'b1, 1'b0, 8'hB2, 5'd6, 1'b0};

      for (int i = 0; i < 16; i++) mem[i] = 8'h00;

      // ---- reset state ----
      tick();
      tick();
      check("rst_rempty",  32'(rempty),   32'd1);
      check("rst_valid",   32'(rd_valid), 32'd0);
      check("rst_data",    32'(rd_data),  32'd0);
      check("rst_rptr",    32'(rptr),     32'd0);
      check("rst_raddr",   32'(raddr),    32'd0);
      check("rst_rclk_en", 32'(rclk_en),  32'd0);
      rrst = 1'b0;

      // ---- single word and backpressure, table driven ----
      for (int i = 0; i < 16; i++) begin
         rd_ready = tbl[i].ready;
         while (wcnt < tbl[i].wtot) begin
            d = (wcnt == 0) ? 8'hA5 : 8'(8'hAF + wcnt);
            write_word(d);
         end
         tick();
         $display("vec %0d: rempty=%0b valid=%0b data=%02h rptr=%02b en=%0b",
                  i, rempty, rd_valid, rd_data, rptr, rclk_en);
         check($sformatf("vec%0d_rempty", i), 32'(rempty),   32'(tbl[i].e_empty));
         check($sformatf("vec%0d_valid", i),  32'(rd_valid), 32'(tbl[i].e_valid));
         check($sformatf("vec%0d_data", i),   32'(rd_data),  32'(tbl[i].e_data));
         check($sformatf("vec%0d_rptr", i),   32'(rptr),     32'(tbl[i].e_rptr));
         check($sformatf("vec%0d_en", i),     32'(rclk_en),  32'(tbl[i].e_en));
      end

      // ---- burst of 16 words, full depth ----
      do_reset();
      for (int k = 0; k < 16; k++) write_word(8'(k));
      rd_ready = 1'b1;
      first_c = -1;
      last_c  = -1;
      cnt     = 0;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (rd_valid) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hXX;
            $display("burst xfer %0d data %02h", cnt, rd_data);
            check("burst_data", 32'(rd_data), 32'(e));
            if (first_c < 0) first_c = c;
            last_c = c;
            cnt++;
         end
      end
      n_done = cnt;
      check("burst_count",  32'(cnt),             32'd16);
      check("burst_consec", 32'(last_c - first_c), 32'd15);
      check("burst_rptr",   32'(rptr),            32'b11000);
      check("burst_rempty", 32'(rempty),          32'd1);

      // ---- randomized stream with wrap, 40 more words in batches of up to 8 ----
      prev_hold = 1'b0;
      prev_data = '0;
      cyc = 0;
      while (!(wcnt == 56 && n_done == 56) && cyc < 2000) begin
         popped = n_done + int'(rd_valid);
         check("rnd_rptr",  32'(rptr),  32'(gray5(popped)));
         check("rnd_raddr", 32'(raddr), 32'(popped % 16));
         if (!rempty) check("rnd_not_empty_has_data", 32'(popped < wcnt), 32'd1);
         if (prev_hold) begin
            check("rnd_hold_valid", 32'(rd_valid), 32'd1);
            check("rnd_hold_data",  32'(rd_data),  32'(prev_data));
         end
         if (wcnt < 56 && $urandom_range(0, 3) == 0) begin
            batch = $urandom_range(1, 8);
            if (batch > 56 - wcnt) batch = 56 - wcnt;
            if (wcnt + batch - n_done <= 16) begin
               for (int b = 0; b < batch; b++) write_word(8'($urandom));
            end
         end
         rd_ready  = (wcnt == 56) ? 1'b1 : ($urandom_range(0, 3) != 0);
         prev_hold = rd_valid && !rd_ready;
         prev_data = rd_data;
         if (rd_valid && rd_ready) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hXX;
            $display("rnd xfer %0d data %02h", n_done, rd_data);
            check("rnd_data", 32'(rd_data), 32'(e));
            n_done++;
         end
         tick();
         cyc++;
      end
      check("rnd_all_delivered", 32'(n_done), 32'd56);
      check("rnd_final_rptr",    32'(rptr),   32'(gray5(56)));

      // ---- asynchronous reset while a word is held ----
      rd_ready = 1'b0;
      for (int k = 0; k < 3; k++) write_word(8'(8'hC0 + k));
      seen = 1'b0;
      for (int c = 0; c < 12 && !seen; c++) begin
         tick();
         seen = rd_valid;
      end
      check("midrst_valid_before", 32'(rd_valid), 32'd1);
      #2;
      rrst = 1'b1;
      #1;
      $display("mid reset: valid=%0b data=%02h rptr=%02b", rd_valid, rd_data, rptr);
      check("midrst_valid",  32'(rd_valid), 32'd0);
      check("midrst_data",   32'(rd_data),  32'd0);
      check("midrst_rptr",   32'(rptr),     32'd0);
      check("midrst_raddr",  32'(raddr),    32'd0);
      check("midrst_rempty", 32'(rempty),   32'd1);
      do_reset();

`ifdef FIFO_RD_LEVEL_EN
      // ---- occupancy with one word parked in the output register ----
      rd_ready = 1'b0;
      for (int k = 0; k < 5; k++) write_word(8'(8'h50 + k));
      for (int c = 0; c < 8; c++) tick();
      $display("level: rlevel=%0d valid=%0b", rlevel, rd_valid);
      check("level_rlevel", 32'(rlevel),   32'd4);
      check("level_valid",  32'(rd_valid), 32'd1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
